// File: rtl/nec_report_if.sv
// Signal bundle between the NEC decoder, the report sequencer and the UART transmitter.
// Handshake: a key or repeat event is a level pulse that the sequencer edge-detects.
// On the UART side the sequencer may raise tx_start for one cycle only while tx_busy
// is low. The UART raises tx_busy on the next cycle and holds it until the byte is done.
interface nec_report_if;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_repeat;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;

  modport master (
    output key_code, key_valid, key_repeat, tx_busy,
    input  tx_data, tx_start
  );

  modport slave (
    input  key_code, key_valid, key_repeat, tx_busy,
    output tx_data, tx_start
  );
endinterface

// File: rtl/nec_report.sv
// NEC report sequencer. It turns key and repeat events into 5-byte ASCII messages
// such as "K45\r\n" and "RA7\r\n". The events wait in a small FIFO, and one FSM sends
// each message to a shared UART one byte at a time.
module nec_report #(
  parameter int FIFO_DEPTH = 4,
  parameter int REPEAT_DIV = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  nec_report_if.slave                   bus,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic [2:0]                    state_dbg
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_HOLD, S_WAIT} state_t;

  logic kv_s1, kv_s2, kv_d, kr_s1, kr_s2, kr_d;
  logic key_edge, rep_edge;
  logic [7:0] last_code, rep_cnt;
  logic has_key;
  logic push_req, push_ok, pop, full;
  logic [8:0] push_entry;
  logic [8:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  state_t state_q, state_d;
  logic send_fire;
  logic msg_rep;
  logic [7:0] msg_code, cur_byte;
  logic [2:0] idx;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Two-flop synchronizers plus a delay flop for edge detection on the slow inputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      {kv_s1, kv_s2, kv_d} <= 3'b000;
      {kr_s1, kr_s2, kr_d} <= 3'b000;
    end else begin
      {kv_s1, kv_s2, kv_d} <= {bus.key_valid, kv_s1, kv_s2};
      {kr_s1, kr_s2, kr_d} <= {bus.key_repeat, kr_s1, kr_s2};
    end
  end

  // A key edge wins over a repeat edge that arrives in the same cycle
  assign key_edge = kv_s2 & ~kv_d;
  assign rep_edge = kr_s2 & ~kr_d & ~key_edge;

  // Choose the entry to push. key_code is stable while key_valid is high, so it can be used raw.
  always_comb begin
    push_req   = 1'b0;
    push_entry = {1'b0, bus.key_code};
    if (key_edge) begin
      push_req = 1'b1;
    end else if (rep_edge && has_key && (rep_cnt == 8'(REPEAT_DIV - 1))) begin
      push_req   = 1'b1;
      push_entry = {1'b1, last_code};
    end
  end

  // Track the last key and divide the repeat events. This state updates even when the FIFO drops the entry.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_code <= 8'h00;
      has_key   <= 1'b0;
      rep_cnt   <= 8'h00;
    end else if (key_edge) begin
      last_code <= bus.key_code;
      has_key   <= 1'b1;
      rep_cnt   <= 8'h00;
    end else if (rep_edge && has_key) begin
      if (rep_cnt == 8'(REPEAT_DIV - 1)) rep_cnt <= 8'h00;
      else                               rep_cnt <= rep_cnt + 8'h01;
    end
  end

  // A push into a full FIFO still fits if a pop happens in the same cycle
  assign full    = (count == (AW + 1)'(FIFO_DEPTH));
  assign push_ok = push_req & (~full | pop);

  // FIFO storage. It has no reset because the pointers decide which entries are valid.
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers, occupancy and the overflow pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req & full & ~pop;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign fifo_level = count;

  // Message sequencer state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next state, FIFO pop and byte launch
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    send_fire = 1'b0;
    case (state_q)
      S_IDLE: if (count != '0) state_d = S_LOAD;
      S_LOAD: begin
        pop     = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: if (!bus.tx_busy) begin
        send_fire = 1'b1;
        state_d   = S_HOLD;
      end
      S_HOLD: state_d = S_WAIT;  // the UART has not raised tx_busy yet
      S_WAIT: if (!bus.tx_busy) state_d = (idx == 3'd4) ? S_IDLE : S_SEND;
      default: state_d = S_IDLE;
    endcase
  end

  // Select the byte of the current message that idx points to
  always_comb begin
    cur_byte = 8'h0A;
    case (idx)
      3'd0:    cur_byte = msg_rep ? 8'h52 : 8'h4B;
      3'd1:    cur_byte = hex_char(msg_code[7:4]);
      3'd2:    cur_byte = hex_char(msg_code[3:0]);
      3'd3:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  // Message register, byte index and the registered UART outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      msg_rep  <= 1'b0;
      msg_code <= 8'h00;
      idx      <= 3'd0;
      bus.tx_data  <= 8'h00;
      bus.tx_start <= 1'b0;
    end else begin
      bus.tx_start <= send_fire;
      if (send_fire) bus.tx_data <= cur_byte;
      if (pop) begin
        {msg_rep, msg_code} <= mem[rd_ptr];
        idx <= 3'd0;
      end else if (state_q == S_WAIT && !bus.tx_busy && idx != 3'd4) begin
        idx <= idx + 3'd1;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;
endmodule

// File: tb/tb_nec_report.sv
// Bench for nec_report. It runs directed scenarios and then random key and repeat
// traffic. A queue of expected UART bytes is filled from a message-level model, and
// a monitor checks each tx_start against the head of that queue.
module tb_nec_report;
  localparam int FIFO_DEPTH = 4;
  localparam int REPEAT_DIV = 4;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic overflow, busy;
  logic [2:0] state_dbg;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  nec_report_if bus();

  nec_report #(.FIFO_DEPTH(FIFO_DEPTH), .REPEAT_DIV(REPEAT_DIV)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus(bus.slave),
    .overflow(overflow),
    .fifo_level(fifo_level),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 sys_clk = ~sys_clk;

  // UART model: busy for 10 cycles after each start. It can also be held busy.
  int   busy_cnt = 0;
  logic hold_busy = 1'b0;
  always @(posedge sys_clk) begin
    if (bus.tx_start)      busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = hold_busy | (busy_cnt != 0);

  // Scoreboard state
  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int start_count = 0;
  int ovf_count = 0;
  logic prev_start = 1'b0;

  // Monitor: every tx_start pops one expected byte
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (bus.tx_start) begin
        logic [7:0] e;
        start_count++;
        checks++;
        if (prev_start) begin
          failures++;
          $display("FAIL tx_start_width: high two samples in a row, required one cycle");
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_byte: tx_data=%02h with no byte expected", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.tx_data !== e) begin
            failures++;
            $display("FAIL tx_byte: actual=%02h expected=%02h", bus.tx_data, e);
          end
        end
      end
      if (overflow) ovf_count++;
    end
    prev_start = bus.tx_start;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model at the message level
  bit         m_has_key = 1'b0;
  logic [7:0] m_last = 8'h00;
  int         m_rep = 0;

  function automatic logic [7:0] hex(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);   // '0'..'9'
    return 8'h41 + 8'(n) - 8'd10;          // 'A'..'F'
  endfunction

  task automatic push_msg(input bit is_rep, input logic [7:0] code);
    exp_q.push_back(is_rep ? 8'h52 : 8'h4B);
    exp_q.push_back(hex(code[7:4]));
    exp_q.push_back(hex(code[3:0]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic model_event(input bit k, input bit r, input logic [7:0] code, input bit dropped);
    if (k) begin
      m_last = code;
      m_has_key = 1'b1;
      m_rep = 0;
      if (!dropped) push_msg(1'b0, code);
    end else if (r && m_has_key) begin
      m_rep++;
      if (m_rep == REPEAT_DIV) begin
        m_rep = 0;
        if (!dropped) push_msg(1'b1, m_last);
      end
    end
  endtask

  // Driver: one level pulse on key_valid, key_repeat or both
  task automatic pulse(input bit k, input bit r, input logic [7:0] code, input int hi, input int lo);
    @(negedge sys_clk);
    bus.key_code   = code;
    bus.key_valid  = k;
    bus.key_repeat = r;
    repeat (hi) @(negedge sys_clk);
    bus.key_valid  = 1'b0;
    bus.key_repeat = 1'b0;
    repeat (lo) @(negedge sys_clk);
  endtask

  task automatic do_event(input bit k, input bit r, input logic [7:0] code, input int hi, input int lo);
    model_event(k, r, code, 1'b0);
    pulse(k, r, code, hi, lo);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    #1;
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    exp_q.delete();
    m_has_key = 1'b0;
    m_rep = 0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Main sequence
  initial begin
    int base, base_ovf, n;
    bus.key_code   = 8'h00;
    bus.key_valid  = 1'b0;
    bus.key_repeat = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_tx_start", bus.tx_start, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_busy", busy, 1'b0);
    sys_rst_n = 1'b1;

    // Single key message
    base = start_count;
    do_event(1'b1, 1'b0, 8'h45, 6, 6);
    wait_drain("key45", 400);
    chk("key45_starts", start_count - base, 5);

    // Key, then 8 repeats: only the 4th and 8th repeats produce a message
    base = start_count;
    do_event(1'b1, 1'b0, 8'hA7, 6, 6);
    for (int i = 0; i < 8; i++) do_event(1'b0, 1'b1, 8'h00, 6, 6);
    wait_drain("repeat_div", 1000);
    chk("repeat_div_starts", start_count - base, 15);

    // Repeats with no key since reset are ignored
    do_reset();
    base = start_count;
    for (int i = 0; i < 4; i++) do_event(1'b0, 1'b1, 8'h11, 6, 6);
    repeat (30) @(negedge sys_clk);
    #1;
    chk("norep_level", fifo_level, 0);
    chk("norep_starts", start_count - base, 0);
    chk("norep_busy", busy, 1'b0);

    // Overflow: the message register takes the first key, then FIFO_DEPTH keys queue and the rest drop
    @(negedge sys_clk);
    hold_busy = 1'b1;
    base = start_count;
    base_ovf = ovf_count;
    for (int i = 0; i < 6; i++) begin
      model_event(1'b1, 1'b0, 8'(i), i >= FIFO_DEPTH + 1);
      pulse(1'b1, 1'b0, 8'(i), 6, 6);
    end
    repeat (10) @(negedge sys_clk);
    #1;
    chk("ovf_level", fifo_level, FIFO_DEPTH);
    chk("ovf_pulses", ovf_count - base_ovf, 6 - (FIFO_DEPTH + 1));
    chk("ovf_no_start", start_count - base, 0);
    @(negedge sys_clk);
    hold_busy = 1'b0;
    wait_drain("ovf_release", 2000);
    chk("ovf_starts", start_count - base, 5 * (FIFO_DEPTH + 1));

    // tx_busy held high while the sequencer waits to send
    @(negedge sys_clk);
    hold_busy = 1'b1;
    base = start_count;
    do_event(1'b1, 1'b0, 8'h3C, 6, 6);
    repeat (50) @(negedge sys_clk);
    #1;
    chk("held_no_start", start_count - base, 0);
    chk("held_busy", busy, 1'b1);
    @(negedge sys_clk);
    hold_busy = 1'b0;
    @(negedge sys_clk);
    #1;
    chk("held_release_start", bus.tx_start, 1'b1);
    wait_drain("held", 400);

    // Reset in the middle of a message
    base = start_count;
    do_event(1'b1, 1'b0, 8'hFF, 6, 6);
    n = 0;
    while (start_count - base < 2 && n < 200) begin
      @(negedge sys_clk);
      #1;
      n++;
    end
    chk("midrst_reached", start_count - base, 2);
    sys_rst_n = 1'b0;
    exp_q.delete();
    m_has_key = 1'b0;
    m_rep = 0;
    #1;
    chk("midrst_tx_start", bus.tx_start, 1'b0);
    chk("midrst_tx_data", bus.tx_data, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_level", fifo_level, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (150) @(negedge sys_clk);
    #1;
    chk("midrst_no_more", start_count - base, 2);
    chk("midrst_idle", busy, 1'b0);

    // Random traffic, spaced so that the FIFO never fills
    base_ovf = ovf_count;
    for (int i = 0; i < 30; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      do_event(kind <= 3 || kind == 9, kind >= 4, 8'($urandom_range(0, 255)),
               $urandom_range(4, 8), $urandom_range(80, 110));
    end
    wait_drain("random", 2000);
    chk("random_no_overflow", ovf_count - base_ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
